score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Game-score engine for the goose-run screen.
- Counts points in BCD while a run is active, freezes the score on collision, and keeps a session high score.
- Raises a speed level every 100 points.
- Each 4-bit digit output is zero-extended by the top level and fed to one 7-segment screen renderer per digit, so the renderers draw score and high score.

Parameters:
- DIGITS, 4, number of BCD digits in score and high score.
- TICK_DIV, 6, frame ticks per point (6 gives 10 points/s at 60 Hz).
- MAX_LEVEL, 15, saturation value of level; must be < 16.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- frame_tick  input  1  one-cycle pulse per video frame.
- start  input  1  one-cycle pulse: begin a new run.
- collide  input  1  goose/obstacle overlap, level or pulse.
- score_bcd  output  4*DIGITS  current score, digit 0 (ones) in bits [3:0].
- hi_bcd  output  4*DIGITS  high score, same packing.
- level  output  4  speed level, 0..MAX_LEVEL.
- running  output  1  high in RUN.
- game_over  output  1  high in OVER.
- point_pulse  output  1  one-cycle pulse on each score increment.
- score_visible  output  1  display enable for the score digits.

Behaviour:
- One clock domain; reset is synchronous and active-high on clk.
- On reset:
  - state = IDLE.
  - score_bcd, hi_bcd, level and the divider are all 0.
  - point_pulse = 0, score_visible = 1.
- FSM states: IDLE, RUN, OVER.
  - IDLE -> RUN on start; score, level and divider are cleared in the same edge.
  - RUN -> OVER on collide.
  - OVER -> RUN on start; score, level and divider are cleared.
  - start is ignored in RUN. collide is ignored in IDLE and OVER.
- Divider, RUN only:
  - Counts frame_tick.
  - When the divider is TICK_DIV-1 and frame_tick is high, the divider returns to 0 and the score is incremented.
  - Divider width is clog2(TICK_DIV).
- Increment:
  - Ripple BCD: a digit at 9 goes to 0 and carries into the next digit.
  - Registered outputs update the cycle after the qualifying tick edge.
  - point_pulse is high for exactly that one cycle.
- Saturation: at all-9s (9999) the score holds; no wrap, no point_pulse.
- Level:
  - Increments when the carry propagates out of the tens digit (score x99 -> (x+1)00).
  - Saturates at MAX_LEVEL.
- Simultaneous events:
  - collide together with a qualifying tick in RUN: collide wins and the score does not increment.
  - start together with collide in OVER: start wins (new run).
- High score:
  - On the RUN -> OVER transition, hi_bcd is loaded with score_bcd if score_bcd > hi_bcd.
  - Compare the packed BCD as unsigned, which is valid because the digit count is fixed.
  - hi_bcd is cleared only by reset.
- Status outputs: running = (state == RUN); game_over = (state == OVER). Both are registered-state decodes.
- Reset mid-run: everything, including hi_bcd, returns to reset values on the next edge.

Optional Feature:
- Macro: SCORE_BLINK_EN.
- Defined:
  - In OVER, score_visible toggles every 32 frame_tick pulses, using a 5-bit blink counter cleared on entry to OVER.
  - score_visible is forced to 1 in other states.
- Undefined:
  - score_visible is tied to 1.
  - No blink counter is synthesized.

Decomposition:
- Package score_pkg holds:
  - the state enum (IDLE, RUN, OVER);
  - BCD_W = 4 and BCD_MAX = 4'd9;
  - BLINK_PERIOD = 32.
- Sub-module bcd_digit:
  - One 4-bit digit register with inputs clr, inc and a carry_out.
  - score_keeper instantiates DIGITS copies in a generate loop.
  - The carry chain is gated by a global not-saturated signal.

Test Plan:
- reset, start, 60 frame_ticks spaced 10 cycles apart, TICK_DIV=6 -> score_bcd = 0x0010, 10 point_pulses, running=1.
- Preload to 0x0099 via ticks, then one more point -> score_bcd = 0x0100, level = 1; at 0x0199 -> 0x0200, level = 2.
- Score 0x0042, collide -> game_over=1 next cycle, hi_bcd = 0x0042. Further ticks -> score unchanged.
- Second run ends at 0x0030 -> hi_bcd stays 0x0042. Third run ends at 0x0057 -> hi_bcd = 0x0057.
- collide on the same cycle as the 6th tick at score 0x0005 -> score stays 0x0005, no point_pulse, state OVER.
- Run to 9999, extra ticks -> score holds 0x9999, point_pulse stays 0. reset -> all outputs 0, score_visible=1. With SCORE_BLINK_EN defined, in OVER: 32 ticks -> score_visible=0, 64 ticks -> score_visible=1.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and constants for the goose-run score engine.
package score_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int         BCD_W        = 4;
  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam int         BLINK_PERIOD = 32;
endpackage

// File: rtl/score_keeper_bcd_digit.sv
// One BCD digit of the score. carry_out flags "this digit is at 9", so an
// increment reaching it ripples on; the parent gates the chain with it.
module bcd_digit
  import score_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] value,
  output logic             carry_out
);
  assign carry_out = (value == BCD_MAX);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      value <= '0;
    end else if (inc) begin
      value <= carry_out ? '0 : value + 4'd1;
    end
  end
endmodule

// File: rtl/score_keeper.sv
// Goose-run score engine: BCD score, session high score, speed level.
// Build option: define SCORE_BLINK_EN to blink the score digits in OVER.
module score_keeper
  import score_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int TICK_DIV  = 6,
  parameter int MAX_LEVEL = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  start,
  input  logic                  collide,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   hi_bcd,
  output logic [3:0]            level,
  output logic                  running,
  output logic                  game_over,
  output logic                  point_pulse,
  output logic                  score_visible
);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t            state, next_state;
  logic [DIV_W-1:0]  div;
  logic [DIGITS-1:0] carry;
  logic [DIGITS-1:0] inc_chain;
  logic              new_run, end_run, tick_due, saturated, score_inc, tens_carry;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)   next_state = RUN;
      RUN:     if (collide) next_state = OVER;
      OVER:    if (start)   next_state = RUN;
      default:              next_state = IDLE;
    endcase
  end

  // Collide beats a same-cycle qualifying tick, so the final score is frozen.
  always_comb begin
    running   = (state == RUN);
    game_over = (state == OVER);
    new_run   = start && (state == IDLE || state == OVER);
    end_run   = (state == RUN) && collide;
    tick_due  = (state == RUN) && frame_tick && (div == DIV_W'(TICK_DIV - 1));
    score_inc = tick_due && !collide && !saturated;
  end

  assign saturated    = &carry;
  assign inc_chain[0] = score_inc;
  assign tens_carry   = inc_chain[1] && carry[1];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .clr       (new_run),
      .inc       (inc_chain[g]),
      .value     (score_bcd[g*BCD_W +: BCD_W]),
      .carry_out (carry[g])
    );
    if (g < DIGITS - 1) begin : g_chain
      assign inc_chain[g+1] = inc_chain[g] && carry[g];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || new_run) begin
      div <= '0;
    end else if (state == RUN && frame_tick) begin
      div <= tick_due ? '0 : div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || new_run) begin
      level <= '0;
    end else if (tens_carry && level != 4'(MAX_LEVEL)) begin
      level <= level + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) point_pulse <= 1'b0;
    else       point_pulse <= score_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_bcd <= '0;
    end else if (end_run && score_bcd > hi_bcd) begin
      hi_bcd <= score_bcd;
    end
  end

`ifdef SCORE_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_PERIOD);
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_vis;

  always_ff @(posedge clk) begin
    if (reset || end_run) begin
      blink_cnt <= '0;
      blink_vis <= 1'b1;
    end else if (state == OVER && frame_tick) begin
      blink_cnt <= blink_cnt + 1'b1;
      if (blink_cnt == BLINK_W'(BLINK_PERIOD - 1)) blink_vis <= ~blink_vis;
    end
  end

  assign score_visible = (state != OVER) || blink_vis;
`else
  assign score_visible = 1'b1;
`endif
endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: decimal game model compared every
// cycle, plus directed literal checks.
module tb_score_keeper;
  localparam int DIGITS    = 4;
  localparam int TICK_DIV  = 6;
  localparam int MAX_LEVEL = 15;
  localparam int SCORE_MAX = 9999;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        collide = 1'b0;
  logic [15:0] score_bcd, hi_bcd;
  logic [3:0]  level;
  logic        running, game_over, point_pulse, score_visible;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  bit chk_en = 1'b0;

  score_keeper #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .MAX_LEVEL(MAX_LEVEL)) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .start         (start),
    .collide       (collide),
    .score_bcd     (score_bcd),
    .hi_bcd        (hi_bcd),
    .level         (level),
    .running       (running),
    .game_over     (game_over),
    .point_pulse   (point_pulse),
    .score_visible (score_visible)
  );

  // clock / reset
  always #5 clk = ~clk;

  // game model in decimal; mode 0 idle, 1 run, 2 over
  typedef struct {
    int score;
    int hi;
    int level;
    int mode;
    int ticks;
    int blink;
    bit pulse;
  } model_t;

  model_t m = '{default: 0};

  function automatic model_t step(model_t cur, bit rst, bit st, bit col, bit tk);
    model_t n = cur;
    n.pulse = 1'b0;
    if (rst) begin
      n = '{default: 0};
    end else if (cur.mode == 1) begin
      if (col) begin
        n.mode  = 2;
        n.blink = 0;
        if (cur.score > cur.hi) n.hi = cur.score;
      end else if (tk) begin
        n.ticks = cur.ticks + 1;
        if (n.ticks == TICK_DIV) begin
          n.ticks = 0;
          if (cur.score < SCORE_MAX) begin
            n.score = cur.score + 1;
            n.pulse = 1'b1;
            if (n.score % 100 == 0 && cur.level < MAX_LEVEL) n.level = cur.level + 1;
          end
        end
      end
    end else if (st) begin
      n.mode  = 1;
      n.score = 0;
      n.level = 0;
      n.ticks = 0;
    end else if (cur.mode == 2 && tk) begin
      n.blink = cur.blink + 1;
    end
    return n;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r = '0;
    int d = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return r;
  endfunction

  function automatic logic exp_visible(model_t cur);
`ifdef SCORE_BLINK_EN
    return (cur.mode != 2) || ((cur.blink / 32) % 2 == 0);
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk) m <= step(m, reset, start, collide, frame_tick);
  always @(posedge clk) pulse_cnt <= pulse_cnt + int'(point_pulse);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("score", 32'(score_bcd), 32'(to_bcd(m.score)));
      chk("hi", 32'(hi_bcd), 32'(to_bcd(m.hi)));
      chk("level", 32'(level), 32'(m.level));
      chk("running", 32'(running), 32'(m.mode == 1));
      chk("game_over", 32'(game_over), 32'(m.mode == 2));
      chk("pulse", 32'(point_pulse), 32'(m.pulse));
      chk("visible", 32'(score_visible), 32'(exp_visible(m)));
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_collide();
    @(negedge clk) collide = 1'b1;
    @(negedge clk) collide = 1'b0;
  endtask

  task automatic burst(input int n);
    @(negedge clk) frame_tick = 1'b1;
    repeat (n) @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic spaced(input int n, input int gap);
    repeat (n) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      repeat (gap - 2) @(negedge clk);
    end
  endtask

  task automatic pts(input int p);
    burst(p * TICK_DIV);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_score"}, 32'(score_bcd), 32'h0);
    chk({tag, "_hi"}, 32'(hi_bcd), 32'h0);
    chk({tag, "_level"}, 32'(level), 32'h0);
    chk({tag, "_running"}, 32'(running), 32'h0);
    chk({tag, "_over"}, 32'(game_over), 32'h0);
    chk({tag, "_pulse"}, 32'(point_pulse), 32'h0);
    chk({tag, "_visible"}, 32'(score_visible), 32'h1);
  endtask

  int p0;

  initial begin
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    chk_reset_state("rst0");

    pulse_collide();
    chk("idle_collide_over", 32'(game_over), 32'h0);

    pulse_start();
    chk("start_running", 32'(running), 32'h1);
    p0 = pulse_cnt;
    spaced(60, 10);
    chk("t60_score", 32'(score_bcd), 32'h0010);
    chk("t60_pulses", 32'(pulse_cnt - p0), 32'd10);
    chk("t60_running", 32'(running), 32'h1);

    pts(89);
    chk("s99", 32'(score_bcd), 32'h0099);
    chk("s99_level", 32'(level), 32'h0);
    pts(1);
    chk("s100", 32'(score_bcd), 32'h0100);
    chk("s100_level", 32'(level), 32'h1);
    pts(99);
    chk("s199", 32'(score_bcd), 32'h0199);
    pts(1);
    chk("s200", 32'(score_bcd), 32'h0200);
    chk("s200_level", 32'(level), 32'h2);

    do_reset();
    pulse_start();
    pts(42);
    pulse_collide();
    chk("c42_over", 32'(game_over), 32'h1);
    chk("c42_hi", 32'(hi_bcd), 32'h0042);
    burst(12);
    chk("c42_frozen", 32'(score_bcd), 32'h0042);

    pulse_start();
    chk("restart_score", 32'(score_bcd), 32'h0);
    pts(30);
    pulse_collide();
    chk("c30_hi", 32'(hi_bcd), 32'h0042);
    pulse_start();
    pts(57);
    pulse_collide();
    chk("c57_hi", 32'(hi_bcd), 32'h0057);

    pulse_start();
    pts(5);
    burst(5);
    @(negedge clk) begin frame_tick = 1'b1; collide = 1'b1; end
    @(negedge clk) begin frame_tick = 1'b0; collide = 1'b0; end
    chk("sim_score", 32'(score_bcd), 32'h0005);
    chk("sim_pulse", 32'(point_pulse), 32'h0);
    chk("sim_over", 32'(game_over), 32'h1);

    @(negedge clk) begin start = 1'b1; collide = 1'b1; end
    @(negedge clk) begin start = 1'b0; collide = 1'b0; end
    chk("startwins_running", 32'(running), 32'h1);
    chk("startwins_score", 32'(score_bcd), 32'h0);

    do_reset();
    pulse_start();
    pts(SCORE_MAX);
    chk("s9999", 32'(score_bcd), 32'h9999);
    chk("s9999_level", 32'(level), 32'(MAX_LEVEL));
    @(negedge clk);
    p0 = pulse_cnt;
    burst(30);
    @(negedge clk);
    chk("sat_score", 32'(score_bcd), 32'h9999);
    chk("sat_pulses", 32'(pulse_cnt - p0), 32'd0);

    pulse_collide();
    burst(32);
`ifdef SCORE_BLINK_EN
    chk("blink32", 32'(score_visible), 32'h0);
`else
    chk("noblink32", 32'(score_visible), 32'h1);
`endif
    burst(32);
    chk("blink64", 32'(score_visible), 32'h1);

    do_reset();
    chk_reset_state("rst1");

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
